// File: rtl/rx_gate_sequencer_pkg.sv
// rx_gate_pkg: shared FSM state encoding and control-register bit positions for the receiver gate
package rx_gate_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      GATE    = 2'd2,
      HOLDOFF = 2'd3
   } state_t;
   localparam int CTRL_EN    = 0;
   localparam int CTRL_FORCE = 1;
   localparam int CTRL_INV   = 2;
   localparam int CTRL_CLR   = 3;
endpackage

// File: rtl/rx_gate_sequencer_if.sv
// rx_gate_sequencer_if: register-bank configuration, trigger input and gate/status outputs
interface rx_gate_sequencer_if #(parameter int STAT_W = 16);
   logic [31:0]       cfg_ctrl;
   logic [31:0]       cfg_delay;
   logic [31:0]       cfg_width;
   logic [31:0]       cfg_holdoff;
   logic              tx_trig;
   logic              rx_gate;
   logic              busy;
   logic [STAT_W-1:0] trig_count;
   logic [STAT_W-1:0] missed_count;
   modport master (
      output cfg_ctrl, cfg_delay, cfg_width, cfg_holdoff, tx_trig,
      input  rx_gate, busy, trig_count, missed_count
   );
   modport slave (
      input  cfg_ctrl, cfg_delay, cfg_width, cfg_holdoff, tx_trig,
      output rx_gate, busy, trig_count, missed_count
   );
endinterface

// File: rtl/rx_gate_sequencer_sat_counter.sv
// sat_counter: event counter that sticks at all-ones, with a level clear taking priority
module sat_counter #(parameter int STAT_W = 16) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              clr,
   output logic [STAT_W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (clr) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/rx_gate_sequencer.sv
// rx_gate_sequencer: trigger -> delay -> gate window -> holdoff receiver gate with trigger statistics
module rx_gate_sequencer
   import rx_gate_pkg::*;
#(
   parameter int CNT_W  = 24,
   parameter int STAT_W = 16
) (
   input logic               ACLK,
   input logic               ARESETN,
   rx_gate_sequencer_if.slave bus
);
   state_t            state, seq_nxt, nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, sh_delay, sh_width, sh_hold;
   logic [CNT_W-1:0]  cfg_d, cfg_w, cfg_h;
   logic [CNT_W+1:0]  p;
   logic              en, force_open, inv, clr;
   logic              trig_q, edge_det, accept, gate_int;
   logic              unused_cfg;
   assign en         = bus.cfg_ctrl[CTRL_EN];
   assign force_open = bus.cfg_ctrl[CTRL_FORCE];
   assign inv        = bus.cfg_ctrl[CTRL_INV];
   assign clr        = bus.cfg_ctrl[CTRL_CLR];
   assign cfg_d      = bus.cfg_delay[CNT_W-1:0];
   assign cfg_w      = bus.cfg_width[CNT_W-1:0];
   assign cfg_h      = bus.cfg_holdoff[CNT_W-1:0];
   assign unused_cfg = ^{bus.cfg_ctrl[31:4], bus.cfg_delay[31:CNT_W],
                         bus.cfg_width[31:CNT_W], bus.cfg_holdoff[31:CNT_W]};
   assign edge_det   = bus.tx_trig & ~trig_q;
   assign accept     = edge_det & en & (state == IDLE);
   assign bus.busy   = state != IDLE;
   // First non-empty phase at or after 'from', returned as {state, preload count}
   function automatic logic [CNT_W+1:0] plan(input state_t from,
                                             input logic [CNT_W-1:0] d, w, h);
      return (from <= DELAY && d != '0) ? {DELAY, d - 1'b1} :
             (from <= GATE  && w != '0) ? {GATE, w - 1'b1}  :
             (h != '0)                  ? {HOLDOFF, h - 1'b1} : {IDLE, {CNT_W{1'b0}}};
   endfunction
   // seq_nxt ignores enable so an abort still leaves the gate open for one more output cycle
   always_comb begin
      p = {state, cnt - 1'b1};
      if (state == IDLE) p = accept ? plan(DELAY, cfg_d, cfg_w, cfg_h) : {IDLE, cnt};
      else if (cnt == '0) p = (state == HOLDOFF) ? {IDLE, cnt}
                                                 : plan(state_t'(state + 2'd1), sh_delay, sh_width, sh_hold);
      seq_nxt  = state_t'(p[CNT_W+1 -: 2]);
      cnt_nxt  = p[CNT_W-1:0];
      nxt      = en ? seq_nxt : IDLE;
      gate_int = force_open | (seq_nxt == GATE);
   end
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         state       <= IDLE;
         cnt         <= '0;
         trig_q      <= 1'b0;
         sh_delay    <= '0;
         sh_width    <= '0;
         sh_hold     <= '0;
         bus.rx_gate <= 1'b0;
      end else begin
         state       <= nxt;
         cnt         <= cnt_nxt;
         trig_q      <= bus.tx_trig;
         bus.rx_gate <= gate_int ^ inv;
         if (accept) begin
            sh_delay <= cfg_d;
            sh_width <= cfg_w;
            sh_hold  <= cfg_h;
         end
      end
   sat_counter #(.STAT_W(STAT_W)) u_trig_cnt (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .inc   (accept),
      .clr   (clr),
      .count (bus.trig_count)
   );
   sat_counter #(.STAT_W(STAT_W)) u_missed_cnt (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .inc   (edge_det & ~accept),
      .clr   (clr),
      .count (bus.missed_count)
   );
endmodule

// File: tb/tb_rx_gate_sequencer.sv
// tb_rx_gate_sequencer: directed checks of gate timing, counters, invert/force, abort and reset
module tb_rx_gate_sequencer;
   logic ACLK = 1'b0;
   logic ARESETN;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] gv, bv;
   always #5 ACLK = ~ACLK;
   rx_gate_sequencer_if #(.STAT_W(16)) bus ();
   rx_gate_sequencer_if #(.STAT_W(4))  bus2 ();
   rx_gate_sequencer #(.CNT_W(24), .STAT_W(16)) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );
   // narrow instance so counter saturation and count aliasing are reachable quickly
   rx_gate_sequencer #(.CNT_W(8), .STAT_W(4)) dut2 (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus2)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge ACLK);
      #1;
   endtask
   task automatic cfg(input logic [31:0] d, w, h);
      bus.cfg_delay   = d;
      bus.cfg_width   = w;
      bus.cfg_holdoff = h;
   endtask
   // pulse tx_trig in cycle 0 and record rx_gate/busy for cycles 0..n-1
   task automatic seq(input int n, input int wr_at, input logic [31:0] wr_val,
                      output logic [31:0] g, output logic [31:0] b);
      g = '0;
      b = '0;
      bus.tx_trig = 1'b1;
      g[0] = bus.rx_gate;
      b[0] = bus.busy;
      for (int i = 1; i < n; i++) begin
         step();
         bus.tx_trig = 1'b0;
         if (i == wr_at) bus.cfg_delay = wr_val;
         g[i] = bus.rx_gate;
         b[i] = bus.busy;
      end
   endtask
   initial begin
      ARESETN = 1'b0;
      bus.tx_trig = 1'b0;
      bus.cfg_ctrl = 32'd4;
      cfg(0, 0, 0);
      bus2.tx_trig = 1'b0;
      bus2.cfg_ctrl = 32'd1;
      bus2.cfg_delay = 0;
      bus2.cfg_width = 0;
      bus2.cfg_holdoff = 0;
      repeat (2) step();
      check("reset_gate_no_invert", bus.rx_gate, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_trig", bus.trig_count, 0);
      check("reset_missed", bus.missed_count, 0);
      #3 ARESETN = 1'b1;
      bus.cfg_ctrl = 32'd1;
      step();
      // basic sequence
      cfg(3, 5, 4);
      step();
      seq(16, -1, 0, gv, bv);
      check("basic_gate", gv, 32'h01F0);
      check("basic_busy", bv, 32'h1FFE);
      check("basic_trig", bus.trig_count, 1);
      check("basic_missed", bus.missed_count, 0);
      // zero-length phases
      cfg(0, 2, 0);
      seq(8, -1, 0, gv, bv);
      check("zero_dh_gate", gv, 32'h6);
      check("zero_dh_busy", bv, 32'h6);
      cfg(0, 0, 3);
      seq(8, -1, 0, gv, bv);
      check("zero_w_gate", gv, 32'h0);
      check("zero_w_busy", bv, 32'hE);
      check("zero_trig", bus.trig_count, 3);
      // clear stats; a coincident edge is not counted
      cfg(0, 0, 0);
      bus.cfg_ctrl = 32'd9;
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      bus.cfg_ctrl = 32'd1;
      step();
      check("clr_trig", bus.trig_count, 0);
      check("clr_missed", bus.missed_count, 0);
      // missed triggers during holdoff and on the return-to-idle cycle
      cfg(1, 2, 10);
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      repeat (8) step();
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      check("miss_holdoff_missed", bus.missed_count, 1);
      check("miss_holdoff_trig", bus.trig_count, 1);
      check("miss_holdoff_busy", bus.busy, 1);
      repeat (3) step();
      check("last_holdoff_busy", bus.busy, 1);
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      check("return_edge_busy", bus.busy, 0);
      check("return_edge_missed", bus.missed_count, 2);
      check("return_edge_trig", bus.trig_count, 1);
      step();
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      check("rearm_trig", bus.trig_count, 2);
      repeat (13) step();
      check("rearm_done_busy", bus.busy, 0);
      bus.tx_trig = 1'b1;
      repeat (20) step();
      bus.tx_trig = 1'b0;
      step();
      check("held_trig", bus.trig_count, 3);
      check("held_missed", bus.missed_count, 2);
      // shadowing: delay write mid-DELAY affects only the next sequence
      cfg(3, 5, 4);
      seq(16, 1, 100, gv, bv);
      check("shadow_gate", gv, 32'h01F0);
      check("shadow_busy", bv, 32'h1FFE);
      bus.cfg_width = 2;
      bus.cfg_holdoff = 0;
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      repeat (99) step();
      check("delay100_pre_gate", bus.rx_gate, 0);
      check("delay100_pre_busy", bus.busy, 1);
      step();
      check("delay100_gate", bus.rx_gate, 1);
      repeat (2) step();
      check("delay100_end_gate", bus.rx_gate, 0);
      check("delay100_end_busy", bus.busy, 0);
      // abort by clearing enable during GATE
      cfg(0, 10, 5);
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      repeat (2) step();
      check("abort_gate_open", bus.rx_gate, 1);
      bus.cfg_ctrl = 32'd0;
      step();
      check("abort_busy", bus.busy, 0);
      check("abort_gate_lag", bus.rx_gate, 1);
      step();
      check("abort_gate_closed", bus.rx_gate, 0);
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      check("disabled_missed", bus.missed_count, 3);
      check("disabled_busy", bus.busy, 0);
      // invert and force
      bus.cfg_ctrl = 32'd5;
      step();
      check("inv_idle", bus.rx_gate, 1);
      cfg(0, 2, 0);
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      check("inv_gate_c1", bus.rx_gate, 0);
      step();
      check("inv_gate_c2", bus.rx_gate, 0);
      step();
      check("inv_gate_after", bus.rx_gate, 1);
      bus.cfg_ctrl = 32'd2;
      repeat (6) step();
      check("force_gate", bus.rx_gate, 1);
      check("force_busy", bus.busy, 0);
      bus.cfg_ctrl = 32'd6;
      step();
      check("force_inv_gate", bus.rx_gate, 0);
      // saturation and count aliasing on the narrow instance
      for (int i = 0; i < 20; i++) begin
         bus2.tx_trig = 1'b1;
         step();
         bus2.tx_trig = 1'b0;
         step();
      end
      check("sat_trig", bus2.trig_count, 4'hF);
      bus2.cfg_ctrl = 32'd0;
      for (int i = 0; i < 17; i++) begin
         bus2.tx_trig = 1'b1;
         step();
         bus2.tx_trig = 1'b0;
         step();
      end
      check("sat_missed", bus2.missed_count, 4'hF);
      check("sat_trig_hold", bus2.trig_count, 4'hF);
      bus2.cfg_ctrl = 32'd1;
      bus2.cfg_delay = 32'd256;
      bus2.cfg_width = 32'd1;
      bus2.tx_trig = 1'b1;
      step();
      bus2.tx_trig = 1'b0;
      check("alias_gate", bus2.rx_gate, 1);
      step();
      check("alias_gate_end", bus2.rx_gate, 0);
      check("alias_busy_end", bus2.busy, 0);
      // asynchronous reset in the middle of GATE
      bus.cfg_ctrl = 32'd1;
      cfg(0, 10, 0);
      bus.tx_trig = 1'b1;
      step();
      bus.tx_trig = 1'b0;
      repeat (2) step();
      check("prereset_gate", bus.rx_gate, 1);
      check("prereset_trig_nonzero", bus.trig_count != 0, 1);
      #2 ARESETN = 1'b0;
      #1;
      check("areset_gate", bus.rx_gate, 0);
      check("areset_busy", bus.busy, 0);
      check("areset_trig", bus.trig_count, 0);
      check("areset_missed", bus.missed_count, 0);
      #3 ARESETN = 1'b1;
      step();
      check("post_reset_busy", bus.busy, 0);
      check("post_reset_gate", bus.rx_gate, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
